// File: rtl/jtcop_colmix_pkg.sv
// Shared types and helpers for the jtcop colour mixer: copy engine states,
// per-layer opacity/priority flags and the brightness scaler.
package jtcop_colmix_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      CP
   } copy_state_t;

   // Returns {opaque, priority msb} for one layer pixel
   function automatic logic [1:0] layer_flags(input logic [7:0] p, input logic en);
      return {(|p[3:0]) & en, p[7]};
   endfunction

   // c * (bright+1) / 16; bright=15 leaves the colour untouched
   function automatic logic [7:0] scale_bright(input logic [7:0] c, input logic [3:0] b);
      logic [11:0] p;
      p = 12'(c) * 12'({1'b0, b} + 5'd1);
      return 8'(p >> 4);
   endfunction

endpackage

// File: rtl/jtcop_pal_copy.sv
// Palette copy engine: on VBLANK start, streams every shadow palette entry
// into the live palette, one entry per clock.
module jtcop_pal_copy
   import jtcop_colmix_pkg::*;
#(
   parameter int PALW = 10
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            lvbl,
   output logic            busy,
   output logic [PALW-1:0] rd_addr,
   input  logic [15:0]     rd_rg,
   input  logic [7:0]      rd_b,
   output logic [PALW-1:0] wr_addr,
   output logic [15:0]     wr_rg,
   output logic [7:0]      wr_b,
   output logic            wr_en
);

   copy_state_t     state, state_nxt;
   logic [PALW-1:0] cnt, cnt_nxt;
   logic            lvbl_l;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         lvbl_l <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         lvbl_l <= lvbl;
      end
   end

   // The shadow read runs one entry ahead of the live write, so CP writes
   // cnt-1 while fetching cnt; the wrap of cnt back to 0 marks the last write.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy      = 1'b0;
      wr_en     = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (lvbl_l && !lvbl) state_nxt = RD;
         end
         RD: begin
            busy      = 1'b1;
            cnt_nxt   = cnt + 1'b1;
            state_nxt = CP;
         end
         CP: begin
            busy    = 1'b1;
            wr_en   = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == '0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_addr = cnt;
   assign wr_addr = cnt - 1'b1;
   assign wr_rg   = rd_rg;
   assign wr_b    = rd_b;

endmodule

// File: rtl/jtcop_colmix_n.sv
// N-layer colour mixer: priority PROM picks the winning layer, palette lookup,
// brightness scaling and blanking, with an optional double-buffered palette.
module jtcop_colmix_n
   import jtcop_colmix_pkg::*;
#(
   parameter  int LAYERS = 4,
   parameter  int PRIW   = 3,
   parameter  int DBUF   = 1,
   localparam int SELW   = $clog2(LAYERS),
   localparam int PALW   = SELW + 8,
   localparam int PROMW  = PRIW + 2*LAYERS
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                pxl_cen,
   input  logic                LHBL,
   input  logic                LVBL,
   input  logic [1:0]          pal_cs,
   input  logic [PALW-1:0]     cpu_addr,
   input  logic [15:0]         cpu_dout,
   input  logic [1:0]          dsn,
   output logic [15:0]         cpu_din,
   input  logic [PRIW-1:0]     prisel,
   input  logic [PROMW-1:0]    prog_addr,
   input  logic [SELW-1:0]     prom_din,
   input  logic                prom_we,
   input  logic [8*LAYERS-1:0] pxl,
   input  logic [LAYERS-1:0]   gfx_en,
   input  logic [3:0]          bright,
   output logic [7:0]          red,
   output logic [7:0]          green,
   output logic [7:0]          blue,
   output logic                LHBL_dly,
   output logic                LVBL_dly,
   output logic                busy
);

   localparam int NPAL = 2**PALW;

   logic [LAYERS-1:0] opq, msb;
   logic [PROMW-1:0]  seladdr;
   logic [7:0]        pxl_d1 [LAYERS];
   logic [7:0]        pxl_d2 [LAYERS];
   logic [SELW-1:0]   prom [2**PROMW];
   logic [SELW-1:0]   prom_q, sel;
   logic [PALW-1:0]   pal_addr;
   logic [2:0]        hb_sr, vb_sr;
   logic [15:0]       pal_rg_q;
   logic [7:0]        pal_b_q;

   logic [15:0]       live_rg [NPAL];
   logic [7:0]        live_b  [NPAL];
   logic [1:0]        lw_rg;
   logic              lw_b;
   logic [PALW-1:0]   lw_addr;
   logic [15:0]       lw_rgd;
   logic [7:0]        lw_bd;

   logic [1:0]        we_rg;
   logic              we_b;
   logic [15:0]       cpu_rg_q;
   logic [7:0]        cpu_b_q;

   always_comb begin
      opq = '0;
      msb = '0;
      for (int i = 0; i < LAYERS; i++) {opq[i], msb[i]} = layer_flags(pxl[8*i +: 8], gfx_en[i]);
   end

   // Pixels and blanking travel alongside the PROM lookup so each layer value
   // is still available when its priority result arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seladdr <= '0;
         prom_q  <= '0;
         hb_sr   <= '0;
         vb_sr   <= '0;
         for (int i = 0; i < LAYERS; i++) begin
            pxl_d1[i] <= '0;
            pxl_d2[i] <= '0;
         end
      end else if (pxl_cen) begin
         seladdr <= {prisel, opq, msb};
         prom_q  <= prom[seladdr];
         hb_sr   <= {hb_sr[1:0], LHBL};
         vb_sr   <= {vb_sr[1:0], LVBL};
         for (int i = 0; i < LAYERS; i++) begin
            pxl_d1[i] <= pxl[8*i +: 8];
            pxl_d2[i] <= pxl_d1[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (prom_we) prom[prog_addr] <= prom_din;
   end

   // A PROM entry pointing past the last layer falls back to the top layer
   assign sel      = (prom_q > SELW'(LAYERS-1)) ? SELW'(LAYERS-1) : prom_q;
   assign pal_addr = {sel, pxl_d2[sel]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pal_rg_q <= '0;
         pal_b_q  <= '0;
         red      <= '0;
         green    <= '0;
         blue     <= '0;
         LHBL_dly <= 1'b0;
         LVBL_dly <= 1'b0;
      end else if (pxl_cen) begin
         pal_rg_q <= live_rg[pal_addr];
         pal_b_q  <= live_b[pal_addr];
         LHBL_dly <= hb_sr[2];
         LVBL_dly <= vb_sr[2];
         if (hb_sr[2] && vb_sr[2]) begin
            red   <= scale_bright(pal_rg_q[7:0], bright);
            green <= scale_bright(pal_rg_q[15:8], bright);
            blue  <= scale_bright(pal_b_q, bright);
         end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (lw_rg[0]) live_rg[lw_addr][7:0]  <= lw_rgd[7:0];
      if (lw_rg[1]) live_rg[lw_addr][15:8] <= lw_rgd[15:8];
      if (lw_b)     live_b[lw_addr]        <= lw_bd;
   end

   assign we_rg   = ~dsn & {2{pal_cs[0]}};
   assign we_b    = ~dsn[0] & pal_cs[1];
   assign cpu_din = pal_cs[0] ? cpu_rg_q : {8'hff, cpu_b_q};

   generate
      if (DBUF != 0) begin : g_dbuf
         logic [15:0]     sh_rg [NPAL];
         logic [7:0]      sh_b  [NPAL];
         logic [PALW-1:0] cp_rd_addr;
         logic [15:0]     cp_rg_q;
         logic [7:0]      cp_b_q;
         logic            cp_we;

         // CPU only ever touches the shadow copy; the engine owns the live one
         always_ff @(posedge clk) begin
            if (we_rg[0]) sh_rg[cpu_addr][7:0]  <= cpu_dout[7:0];
            if (we_rg[1]) sh_rg[cpu_addr][15:8] <= cpu_dout[15:8];
            if (we_b)     sh_b[cpu_addr]        <= cpu_dout[7:0];
            cpu_rg_q <= sh_rg[cpu_addr];
            cpu_b_q  <= sh_b[cpu_addr];
            cp_rg_q  <= sh_rg[cp_rd_addr];
            cp_b_q   <= sh_b[cp_rd_addr];
         end

         jtcop_pal_copy #(.PALW(PALW)) u_copy (
            .clk     (clk),
            .rst     (rst),
            .lvbl    (LVBL),
            .busy    (busy),
            .rd_addr (cp_rd_addr),
            .rd_rg   (cp_rg_q),
            .rd_b    (cp_b_q),
            .wr_addr (lw_addr),
            .wr_rg   (lw_rgd),
            .wr_b    (lw_bd),
            .wr_en   (cp_we)
         );

         assign lw_rg = {2{cp_we}};
         assign lw_b  = cp_we;
      end else begin : g_direct
         assign busy    = 1'b0;
         assign lw_addr = cpu_addr;
         assign lw_rgd  = cpu_dout;
         assign lw_bd   = cpu_dout[7:0];
         assign lw_rg   = we_rg;
         assign lw_b    = we_b;

         always_ff @(posedge clk) begin
            cpu_rg_q <= live_rg[cpu_addr];
            cpu_b_q  <= live_b[cpu_addr];
         end
      end
   endgenerate

endmodule

// File: tb/tb_jtcop_colmix_n.sv
// Directed bench for jtcop_colmix_n: a 4-layer double-buffered build and a
// 6-layer direct-palette build sharing one clock and stimulus bus.
module tb_jtcop_colmix_n;

   typedef struct {
      string       name;
      logic [2:0]  prisel;
      logic [31:0] pxl;
      logic [3:0]  en;
      logic [3:0]  bright;
      logic [23:0] rgb;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, pxl_cen, LHBL, LVBL;
   logic [1:0]  pal_cs, pal_cs6, dsn;
   logic [10:0] cpu_addr;
   logic [15:0] cpu_dout;
   logic [13:0] prog_addr;
   logic [2:0]  prom_din;
   logic        prom_we, prom_we6;
   logic [2:0]  prisel;
   logic [47:0] pxl;
   logic [5:0]  gfx_en;
   logic [3:0]  bright;

   logic [15:0] cpu_din, cpu_din6;
   logic [7:0]  red, green, blue, red6, green6, blue6;
   logic        hb_dly, vb_dly, busy, hb_dly6, vb_dly6, busy6;

   int   check_cnt = 0;
   int   pass_cnt  = 0;
   vec_t vecs [9];

   jtcop_colmix_n #(.LAYERS(4), .PRIW(3), .DBUF(1)) dut (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
      .pal_cs(pal_cs), .cpu_addr(cpu_addr[9:0]), .cpu_dout(cpu_dout), .dsn(dsn),
      .cpu_din(cpu_din), .prisel(prisel), .prog_addr(prog_addr[10:0]),
      .prom_din(prom_din[1:0]), .prom_we(prom_we), .pxl(pxl[31:0]),
      .gfx_en(gfx_en[3:0]), .bright(bright), .red(red), .green(green), .blue(blue),
      .LHBL_dly(hb_dly), .LVBL_dly(vb_dly), .busy(busy)
   );

   jtcop_colmix_n #(.LAYERS(6), .PRIW(2), .DBUF(0)) dut6 (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
      .pal_cs(pal_cs6), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .dsn(dsn),
      .cpu_din(cpu_din6), .prisel(prisel[1:0]), .prog_addr(prog_addr),
      .prom_din(prom_din), .prom_we(prom_we6), .pxl(pxl),
      .gfx_en(gfx_en), .bright(bright), .red(red6), .green(green6), .blue(blue6),
      .LHBL_dly(hb_dly6), .LVBL_dly(vb_dly6), .busy(busy6)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic checkOutput(input string name, input logic [23:0] exp);
      checkVal(name, {8'h00, red, green, blue}, {8'h00, exp});
   endtask

   task automatic tick();
      pxl_cen = 1'b1;
      @(posedge clk);
      #1 pxl_cen = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic applyStimulus(input vec_t v);
      prisel = v.prisel;
      pxl    = {16'h0000, v.pxl};
      gfx_en = {2'b11, v.en};
      bright = v.bright;
      ticks(4);
   endtask

   task automatic cpu_write(input bit six, input logic [10:0] addr,
                            input logic [15:0] rg, input logic [7:0] b);
      cpu_addr = addr;
      cpu_dout = rg;
      dsn      = 2'b00;
      if (six) pal_cs6 = 2'b01; else pal_cs = 2'b01;
      @(posedge clk);
      #1 cpu_dout = {8'h00, b};
      dsn = 2'b10;
      if (six) pal_cs6 = 2'b10; else pal_cs = 2'b10;
      @(posedge clk);
      #1 pal_cs = 2'b00;
      pal_cs6 = 2'b00;
      dsn     = 2'b11;
   endtask

   // Priority table: bank 1 falls back to layer 1 when layer 2 is not opaque
   function automatic logic [2:0] prom_val(input logic [10:0] a);
      case (a[10:8])
         3'd0:    return 3'd2;
         3'd1:    return a[6] ? 3'd2 : 3'd1;
         3'd2:    return 3'd0;
         3'd3:    return 3'd1;
         3'd4:    return 3'd3;
         default: return 3'd0;
      endcase
   endfunction

   // Drops LVBL, pokes a second falling edge mid-copy, and counts busy clocks
   task automatic run_copy(output int n);
      int w;
      LVBL = 1'b0;
      n = 0;
      w = 0;
      while (!busy && w < 20) begin @(posedge clk); #1; w++; end
      while (busy && n < 3000) begin
         @(posedge clk);
         #1 n++;
         if (n == 10) LVBL = 1'b1;
         if (n == 12) LVBL = 1'b0;
      end
   endtask

   initial begin
      int n;
      int w;

      vecs[0] = '{"sel2_b15",   3'd0, 32'h0005_0000, 4'hF,    4'd15, 24'h55AACC};
      vecs[1] = '{"sel2_b7",    3'd0, 32'h0005_0000, 4'hF,    4'd7,  24'h2A5566};
      vecs[2] = '{"sel2_b0",    3'd0, 32'h0005_0000, 4'hF,    4'd0,  24'h050A0C};
      vecs[3] = '{"sel2_pix0",  3'd0, 32'h0000_0000, 4'hF,    4'd15, 24'h221133};
      vecs[4] = '{"gfx_en2_off",3'd1, 32'h0005_0A00, 4'b1011, 4'd15, 24'h341256};
      vecs[5] = '{"gfx_en2_on", 3'd1, 32'h0005_0A00, 4'hF,    4'd15, 24'h55AACC};
      vecs[6] = '{"sel0_msb",   3'd2, 32'h0000_0083, 4'hF,    4'd15, 24'hBC9ADE};
      vecs[7] = '{"sel3_b7",    3'd4, 32'h0F00_0000, 4'hF,    4'd7,  24'h077840};
      vecs[8] = '{"sel0_b11",   3'd2, 32'h0000_0083, 4'hF,    4'd11, 24'h8D73A6};

      rst = 1'b1; pxl_cen = 1'b1; LHBL = 1'b1; LVBL = 1'b1;
      pal_cs = 2'b00; pal_cs6 = 2'b00; dsn = 2'b11; cpu_addr = '0; cpu_dout = '0;
      prog_addr = '0; prom_din = '0; prom_we = 1'b0; prom_we6 = 1'b0;
      prisel = '0; pxl = '0; gfx_en = 6'h3F; bright = 4'd15;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_rgb", 24'h000000);
      checkVal("reset_hb_dly", hb_dly, 0);
      checkVal("reset_vb_dly", vb_dly, 0);
      checkVal("reset_busy", busy, 0);
      pxl_cen = 1'b0;
      rst = 1'b0;
      LHBL = 1'b0;

      for (int a = 0; a < 2048; a++) begin
         prog_addr = 14'(a);
         prom_din  = prom_val(11'(a));
         prom_we   = 1'b1;
         @(posedge clk);
         #1;
      end
      prom_we   = 1'b0;
      prog_addr = 14'h1800;
      prom_din  = 3'd7;
      prom_we6  = 1'b1;
      @(posedge clk);
      #1 prom_we6 = 1'b0;

      cpu_write(0, 11'h200, 16'h1122, 8'h33);
      cpu_write(0, 11'h205, 16'hAA55, 8'hCC);
      cpu_write(0, 11'h10A, 16'h1234, 8'h56);
      cpu_write(0, 11'h083, 16'h9ABC, 8'hDE);
      cpu_write(0, 11'h30F, 16'hF00F, 8'h80);
      cpu_write(0, 11'h0FF, 16'h0102, 8'h03);
      cpu_write(0, 11'h100, 16'h2122, 8'h23);
      cpu_write(1, 11'h53C, 16'hA55A, 8'h3C);

      cpu_addr = 11'h205;
      pal_cs = 2'b01;
      @(posedge clk);
      #1 checkVal("cpu_din_rg", cpu_din, 32'h0000AA55);
      pal_cs = 2'b10;
      @(posedge clk);
      #1 checkVal("cpu_din_b", cpu_din, 32'h0000FFCC);
      pal_cs = 2'b00;

      run_copy(n);
      checkVal("copy_cycles", n, 1025);
      LVBL = 1'b1;
      LHBL = 1'b1;

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i].name, vecs[i].rgb);
      end

      applyStimulus(vecs[3]);
      pxl = 48'h0000_0005_0000;
      ticks(3);
      checkOutput("latency_3cen", 24'h221133);
      tick();
      checkOutput("latency_4cen", 24'h55AACC);

      LHBL = 1'b0;
      ticks(3);
      checkVal("hb_dly_3cen", hb_dly, 1);
      tick();
      checkVal("hb_dly_4cen", hb_dly, 0);
      checkOutput("hblank_rgb", 24'h000000);
      LHBL = 1'b1;
      ticks(4);
      checkOutput("unblank", 24'h55AACC);

      cpu_write(0, 11'h205, 16'h7766, 8'h99);
      ticks(4);
      checkOutput("mid_frame_hold", 24'h55AACC);
      run_copy(n);
      checkVal("copy_cycles_retrig", n, 1025);
      repeat (5) @(posedge clk);
      #1 checkVal("busy_after_copy", busy, 0);
      LVBL = 1'b1;
      ticks(4);
      checkOutput("after_vblank", 24'h667799);

      cpu_write(0, 11'h0FF, 16'h0F0E, 8'h0D);
      cpu_write(0, 11'h100, 16'h2F2E, 8'h2D);
      LVBL = 1'b0;
      w = 0;
      while (!busy && w < 20) begin @(posedge clk); #1; w++; end
      checkVal("copy_started", busy, 1);
      repeat (257) @(posedge clk);
      #1 rst = 1'b1;
      #1 checkVal("busy_on_rst", busy, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      LVBL = 1'b1;
      LHBL = 1'b1;
      applyStimulus('{"rst_new_0ff", 3'd2, 32'h0000_00FF, 4'hF, 4'd15, 24'h0E0F0D});
      checkOutput("rst_new_0ff", 24'h0E0F0D);
      applyStimulus('{"rst_old_100", 3'd3, 32'h0000_0000, 4'hF, 4'd15, 24'h222123});
      checkOutput("rst_old_100", 24'h222123);
      checkVal("idle_after_rst", busy, 0);

      prisel = 3'd1;
      pxl    = 48'h3C00_0000_0000;
      gfx_en = 6'h3F;
      bright = 4'd15;
      ticks(4);
      checkVal("l6_sel7_clamp", {8'h00, red6, green6, blue6}, 32'h005AA53C);
      checkVal("l6_busy_tied", busy6, 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
